// File: rtl/pragmatic_weight_encoder.sv
// Pragmatic weight encoder: splits a group of signed weights into essential-bit terms,
// lowest bit first, producing per-lane sign/1st-stage shift and a shared 2nd-stage shift.
module pragmatic_weight_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int OFFSET_MAX = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0] w_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_first,
    output logic                             out_last,
    output logic [VEC_LENGTH-1:0]            is_neg,
    output logic [2*VEC_LENGTH-1:0]          shift_1st_sel,
    output logic [VEC_LENGTH-1:0]            shift_1st_en,
    output logic [$clog2(DATA_WIDTH)-1:0]    shift_2nd_sel,
    output logic                             shift_2nd_en
);

    localparam int SEL2_W = $clog2(DATA_WIDTH);
    localparam logic [SEL2_W-1:0]     OFF_MAX = SEL2_W'(OFFSET_MAX);
    localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] rem_q [VEC_LENGTH];
    logic [VEC_LENGTH-1:0] sign_q;
    logic                  first_q;

    logic [SEL2_W-1:0]     lsb_pos [VEC_LENGTH];
    logic [DATA_WIDTH-1:0] rem_d   [VEC_LENGTH];
    logic [VEC_LENGTH-1:0] lane_nz;
    logic [VEC_LENGTH-1:0] lane_en;
    logic [2*VEC_LENGTH-1:0] lane_sel;
    logic [SEL2_W-1:0]     base;
    logic                  base_found;
    logic                  term_last;
    logic                  fire;
    logic                  accept;

    function automatic logic [SEL2_W-1:0] lowest_set(input logic [DATA_WIDTH-1:0] v);
        logic [SEL2_W-1:0] idx;
        idx = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL2_W'(i);
        end
        return idx;
    endfunction

    // Term decode is purely combinational from the remaining-bit masks.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        base       = '0;
        base_found = 1'b0;
        lane_en    = '0;
        lane_sel   = '0;
        term_last  = 1'b1;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            lane_nz[j] = |rem_q[j];
            lsb_pos[j] = lowest_set(rem_q[j]);
            if (lane_nz[j] && (!base_found || lsb_pos[j] < base)) begin
                base       = lsb_pos[j];
                base_found = 1'b1;
            end
        end
        for (int j = 0; j < VEC_LENGTH; j++) begin
            logic [SEL2_W-1:0]     offs;
            logic [DATA_WIDTH-1:0] clr_mask;
            offs       = lsb_pos[j] - base;
            lane_en[j] = lane_nz[j] && (offs <= OFF_MAX);
            if (lane_en[j]) lane_sel[2*j +: 2] = offs[1:0];
            clr_mask   = lane_en[j] ? (ONE << lsb_pos[j]) : '0;
            rem_d[j]   = rem_q[j] & ~clr_mask;
            if (|rem_d[j]) term_last = 1'b0;
        end
    end

    assign out_valid = (state_q == ENCODE);
    assign fire      = out_valid && out_ready;
    // Back-to-back groups: a new group may load in the same cycle the last term retires.
    assign w_ready   = (state_q == IDLE) || (fire && term_last);
    assign accept    = w_valid && w_ready;

    always_comb begin
        out_first     = out_valid && first_q;
        out_last      = out_valid && term_last;
        is_neg        = out_valid ? sign_q   : '0;
        shift_1st_en  = out_valid ? lane_en  : '0;
        shift_1st_sel = out_valid ? lane_sel : '0;
        shift_2nd_sel = out_valid ? base     : '0;
        shift_2nd_en  = out_valid && (|lane_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= '0;
            first_q <= 1'b0;
            // NOTE: the mask array is small and its zero state defines "nothing pending", so it is reset.
            for (int j = 0; j < VEC_LENGTH; j++) rem_q[j] <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            state_q <= ENCODE;
            first_q <= 1'b1;
            for (int j = 0; j < VEC_LENGTH; j++) begin
                logic [DATA_WIDTH-1:0] w;
                w         = w_in[j*DATA_WIDTH +: DATA_WIDTH];
                sign_q[j] <= w[DATA_WIDTH-1];
                // Two's-complement negate; the most negative value maps to its own magnitude bit.
                rem_q[j]  <= w[DATA_WIDTH-1] ? (~w + ONE) : w;
            end
        end else if (fire) begin
            first_q <= 1'b0;
            for (int j = 0; j < VEC_LENGTH; j++) rem_q[j] <= rem_d[j];
            if (term_last) state_q <= IDLE;
        end
    end

endmodule

// File: tb/tb_pragmatic_weight_encoder.sv
// Directed self-checking bench for pragmatic_weight_encoder with hand-computed terms.
module tb_pragmatic_weight_encoder;

    localparam int DW = 8;
    localparam int VL = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             w_valid;
    logic             w_ready;
    logic [VL*DW-1:0] w_in;
    logic             out_valid;
    logic             out_ready;
    logic             out_first;
    logic             out_last;
    logic [VL-1:0]    is_neg;
    logic [2*VL-1:0]  shift_1st_sel;
    logic [VL-1:0]    shift_1st_en;
    logic [2:0]       shift_2nd_sel;
    logic             shift_2nd_en;

    int n_compared   = 0;
    int n_mismatched = 0;

    pragmatic_weight_encoder #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .OFFSET_MAX(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_in          (w_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_first     (out_first),
        .out_last      (out_last),
        .is_neg        (is_neg),
        .shift_1st_sel (shift_1st_sel),
        .shift_1st_en  (shift_1st_en),
        .shift_2nd_sel (shift_2nd_sel),
        .shift_2nd_en  (shift_2nd_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input int val);
        w_in[lane*DW +: DW] = DW'(val);
    endtask

    // Full view of one term: valid/first/last, 2nd stage, lane enables/selects/signs.
    task automatic expect_term(input string tag, input logic f, input logic l,
                               input logic [2:0] s2, input logic e2,
                               input logic [VL-1:0] en, input logic [2*VL-1:0] sel,
                               input logic [VL-1:0] neg);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
        check({tag, ".first"}, 32'(out_first), 32'(f));
        check({tag, ".last"},  32'(out_last),  32'(l));
        check({tag, ".sel2"},  32'(shift_2nd_sel), 32'(s2));
        check({tag, ".en2"},   32'(shift_2nd_en),  32'(e2));
        check({tag, ".en1"},   32'(shift_1st_en),  32'(en));
        check({tag, ".sel1"},  32'(shift_1st_sel), 32'(sel));
        check({tag, ".neg"},   32'(is_neg), 32'(neg));
    endtask

    task automatic expect_idle(input string tag);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(1'b0));
        check({tag, ".ready"}, 32'(w_ready),   32'(1'b1));
        check({tag, ".first"}, 32'(out_first), 32'(1'b0));
        check({tag, ".last"},  32'(out_last),  32'(1'b0));
        check({tag, ".en1"},   32'(shift_1st_en),  32'(0));
        check({tag, ".sel1"},  32'(shift_1st_sel), 32'(0));
        check({tag, ".sel2"},  32'(shift_2nd_sel), 32'(0));
        check({tag, ".en2"},   32'(shift_2nd_en),  32'(0));
        check({tag, ".neg"},   32'(is_neg), 32'(0));
    endtask

    // Present a group and let it be accepted on the next edge.
    task automatic send_group();
        w_valid = 1'b1;
        #1;
        check("accept.ready", 32'(w_ready), 32'(1'b1));
        step();
        w_valid = 1'b0;
        w_in    = '0;
    endtask

    initial begin
        reset = 1'b1; w_valid = 1'b0; w_in = '0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        expect_idle("rst");

        // All-zero group: single empty term carrying first and last.
        w_in = '0;
        send_group();
        expect_term("zero", 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 16'h0000, 8'h00);
        step();
        expect_idle("zero.end");

        // w0 = 5 -> bits 0 and 2.
        set_lane(0, 5);
        send_group();
        expect_term("w5.t1", 1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 16'h0000, 8'h00);
        step();
        expect_term("w5.t2", 1'b0, 1'b1, 3'd2, 1'b1, 8'h01, 16'h0000, 8'h00);
        step();
        expect_idle("w5.end");

        // w0=1, w1=16 (out of window at first), w2=-3 (|3| = 0b11).
        set_lane(0, 1); set_lane(1, 16); set_lane(2, -3);
        send_group();
        expect_term("mix.t1", 1'b1, 1'b0, 3'd0, 1'b1, 8'h05, 16'h0000, 8'h04);
        step();
        expect_term("mix.t2", 1'b0, 1'b1, 3'd1, 1'b1, 8'h06, 16'h000C, 8'h04);
        step();
        expect_idle("mix.end");

        // Most negative weight.
        set_lane(3, -128);
        send_group();
        expect_term("m128", 1'b1, 1'b1, 3'd7, 1'b1, 8'h08, 16'h0000, 8'h08);
        step();
        expect_idle("m128.end");

        // Backpressure on group A (w0=3), with an ignored w_valid while not ready.
        set_lane(0, 3);
        send_group();
        out_ready = 1'b0;
        w_valid   = 1'b1;
        set_lane(0, 8'h55);
        for (int c = 0; c < 3; c++) begin
            expect_term("stall", 1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 16'h0000, 8'h00);
            check("stall.ready", 32'(w_ready), 32'(1'b0));
            step();
        end
        expect_term("stall.rel", 1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 16'h0000, 8'h00);
        out_ready = 1'b1;
        w_valid   = 1'b0;
        w_in      = '0;
        step();
        // Last term of A: group B (w0=2) rides in on the same edge.
        expect_term("A.t2", 1'b0, 1'b1, 3'd1, 1'b1, 8'h01, 16'h0000, 8'h00);
        set_lane(0, 2);
        send_group();
        expect_term("B.t1", 1'b1, 1'b1, 3'd1, 1'b1, 8'h01, 16'h0000, 8'h00);
        step();
        expect_idle("B.end");

        // Reset during term 2 of a 3-term group (w0=7).
        set_lane(0, 7);
        send_group();
        expect_term("r7.t1", 1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 16'h0000, 8'h00);
        step();
        expect_term("r7.t2", 1'b0, 1'b0, 3'd1, 1'b1, 8'h01, 16'h0000, 8'h00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_idle("r7.rst");

        // Fresh group after reset: w1 = -6 (|6| = 0b110).
        set_lane(1, -6);
        send_group();
        expect_term("n6.t1", 1'b1, 1'b0, 3'd1, 1'b1, 8'h02, 16'h0000, 8'h02);
        step();
        expect_term("n6.t2", 1'b0, 1'b1, 3'd2, 1'b1, 8'h02, 16'h0000, 8'h02);
        step();
        expect_idle("n6.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
